// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices, result latencies and the
// in-flight write tracker entry used by the EX forwarding scoreboard.
package pipe_pkg;

  localparam int STG_EXMEM = 1;
  localparam int STG_MEMWB = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Field widths of the tracker entry; scoreboard AW/LW are expected to match.
  localparam int REG_AW = 5;
  localparam int LAT_W  = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [LAT_W-1:0]  lat;
  } trk_entry_t;

  // A result is never ready before EX/MEM nor later than the last tracked stage.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat,
                                                 input int depth);
    int l;
    l = int'(lat);
    if (l < 1) l = 1;
    if (l > depth) l = depth;
    return LAT_W'(l);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX-stage operand bus between the pipeline (master) and the forwarding
// scoreboard (slave).
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int LW      = 2,
  parameter int SW      = 2,
  parameter int CW      = 16
);
  // Handshake: ex_valid_i marks a real EX instruction and stall_o is its
  // inverted ready; the instruction leaves EX on a clock edge where
  // ex_valid_i=1, stall_o=0 and hold_i=0, otherwise EX keeps it.
  logic                  ex_valid_i;
  logic                  ex_regwr_i;
  logic [AW-1:0]         ex_rd_i;
  logic [LW-1:0]         ex_lat_i;
  logic [NUM_SRC*AW-1:0] ex_src_i;
  logic                  flush_i;
  logic                  hold_i;
  logic [NUM_SRC*SW-1:0] fwd_sel_o;
  logic                  stall_o;
  logic [CW-1:0]         stall_cnt_o;

  modport master (
    output ex_valid_i, ex_regwr_i, ex_rd_i, ex_lat_i, ex_src_i, flush_i, hold_i,
    input  fwd_sel_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  ex_valid_i, ex_regwr_i, ex_rd_i, ex_lat_i, ex_src_i, flush_i, hold_i,
    output fwd_sel_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_src_match.sv
// Youngest-first producer search for one EX source operand: returns the
// forwarding stage, or a stall request when that producer is not ready yet.
module fwd_src_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int SW    = 2
) (
  input  logic [AW-1:0]          src,
  input  trk_entry_t [DEPTH-1:0] entries,
  output logic [SW-1:0]          sel,
  output logic                   stall
);

  logic found;

  // entries[k] sits at stage k+1; the first hit is the youngest producer.
  always_comb begin
    sel   = '0;
    stall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && (src != '0) && entries[k].valid &&
          (entries[k].rd == REG_AW'(src))) begin
        found = 1'b1;
        if (k + 1 >= int'(entries[k].lat)) begin
          sel = SW'(k + 1);
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX forwarding scoreboard: tracks in-flight register writes over DEPTH
// post-EX stages and drives per-source forwarding selects and the EX stall.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int AW      = REG_AW,
  parameter int LW      = LAT_W,
  parameter int SW      = $clog2(DEPTH + 1),
  parameter int CW      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fwd_scoreboard_if.slave  bus
);

  trk_entry_t [DEPTH-1:0] trk;
  trk_entry_t             new_e;
  logic [NUM_SRC-1:0]     stall_req;
  logic [SW-1:0]          sel_n [NUM_SRC];
  logic                   stall;
  logic [CW-1:0]          stall_cnt;

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    fwd_src_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .SW    (SW)
    ) u_match (
      .src     (bus.ex_src_i[n*AW +: AW]),
      .entries (trk),
      .sel     (sel_n[n]),
      .stall   (stall_req[n])
    );
    assign bus.fwd_sel_o[n*SW +: SW] = sel_n[n];
  end

  // The EX instruction's own destination plays no part in its stall.
  assign stall = bus.ex_valid_i & (|stall_req);

  // A stalled or flushed EX instruction enters the tracker as a bubble.
  always_comb begin
    new_e       = '0;
    new_e.valid = bus.ex_valid_i & bus.ex_regwr_i & ~bus.flush_i & ~stall;
    new_e.rd    = REG_AW'(bus.ex_rd_i);
    new_e.lat   = clamp_lat(LAT_W'(bus.ex_lat_i), DEPTH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trk       <= '0;
      stall_cnt <= '0;
    end else if (!bus.hold_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        trk[k] <= trk[k-1];
      end
      trk[0] <= new_e;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: an in-flight producer list model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_fwd_scoreboard;
  import pipe_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int AW      = 5;
  localparam int LW      = 2;
  localparam int SW      = 2;
  localparam int CW      = 16;
  localparam int CW_SAT  = 2;
  localparam int CNT_MAX     = (1 << CW) - 1;
  localparam int CNT_SAT_MAX = (1 << CW_SAT) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  fwd_scoreboard_if #(.NUM_SRC(NUM_SRC), .AW(AW), .LW(LW), .SW(SW), .CW(CW))     bus0 ();
  fwd_scoreboard_if #(.NUM_SRC(NUM_SRC), .AW(AW), .LW(LW), .SW(SW), .CW(CW_SAT)) bus1 ();

  assign bus1.ex_valid_i = bus0.ex_valid_i;
  assign bus1.ex_regwr_i = bus0.ex_regwr_i;
  assign bus1.ex_rd_i    = bus0.ex_rd_i;
  assign bus1.ex_lat_i   = bus0.ex_lat_i;
  assign bus1.ex_src_i   = bus0.ex_src_i;
  assign bus1.flush_i    = bus0.flush_i;
  assign bus1.hold_i     = bus0.hold_i;

  fwd_scoreboard #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .AW(AW), .LW(LW), .SW(SW), .CW(CW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  fwd_scoreboard #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .AW(AW), .LW(LW), .SW(SW), .CW(CW_SAT)) u_dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  // ---------------- scoreboard model ----------------
  typedef struct {
    int rd;
    int lat;
    int age;
  } flight_t;

  flight_t inflight[$];
  int      m_cnt;
  int      m_cnt_sat;
  int      checks;
  int      errors;
  bit      chk_en;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_src(input int src, output int sel, output bit stl);
    int best_age;
    int best_lat;
    best_age = 0;
    best_lat = 0;
    foreach (inflight[i]) begin
      if (src != 0 && inflight[i].rd == src &&
          (best_age == 0 || inflight[i].age < best_age)) begin
        best_age = inflight[i].age;
        best_lat = inflight[i].lat;
      end
    end
    sel = 0;
    stl = 1'b0;
    if (best_age != 0) begin
      if (best_age >= best_lat) sel = best_age;
      else stl = 1'b1;
    end
  endfunction

  function automatic bit model_stall();
    int s;
    bit t;
    bit any;
    any = 1'b0;
    for (int n = 0; n < NUM_SRC; n++) begin
      model_src(int'(bus0.ex_src_i[n*AW +: AW]), s, t);
      any |= t;
    end
    return bus0.ex_valid_i & any;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit wr, input int rd, input int lat,
                       input int s0, input int s1, input bit fl, input bit hd);
    bus0.ex_valid_i = v;
    bus0.ex_regwr_i = wr;
    bus0.ex_rd_i    = AW'(rd);
    bus0.ex_lat_i   = LW'(lat);
    bus0.ex_src_i   = {AW'(s1), AW'(s0)};
    bus0.flush_i    = fl;
    bus0.hold_i     = hd;
  endtask

  // Compare both DUTs against the model in the middle of the cycle.
  task automatic sample();
    logic [NUM_SRC*SW-1:0] exp_sel;
    int  s;
    bit  t;
    bit  any;
    bit  exp_stall;
    @(negedge clk);
    if (chk_en) begin
      exp_sel = '0;
      any     = 1'b0;
      for (int n = 0; n < NUM_SRC; n++) begin
        model_src(int'(bus0.ex_src_i[n*AW +: AW]), s, t);
        exp_sel[n*SW +: SW] = SW'(s);
        any |= t;
      end
      exp_stall = bus0.ex_valid_i & any;
      chk("model_fwd_sel",       32'(bus0.fwd_sel_o),   int'(exp_sel));
      chk("model_stall",         32'(bus0.stall_o),     int'(exp_stall));
      chk("model_stall_cnt",     32'(bus0.stall_cnt_o), m_cnt);
      chk("model_fwd_sel_sat",   32'(bus1.fwd_sel_o),   int'(exp_sel));
      chk("model_stall_sat",     32'(bus1.stall_o),     int'(exp_stall));
      chk("model_stall_cnt_sat", 32'(bus1.stall_cnt_o), m_cnt_sat);
    end
  endtask

  // Clock edge: advance the model with the inputs the DUT sees, then move off the edge.
  task automatic advance();
    bit st;
    int l;
    @(posedge clk);
    if (rst) begin
      inflight.delete();
      m_cnt     = 0;
      m_cnt_sat = 0;
    end else if (!bus0.hold_i) begin
      st = model_stall();
      foreach (inflight[i]) inflight[i].age++;
      for (int i = inflight.size() - 1; i >= 0; i--) begin
        if (inflight[i].age > DEPTH) inflight.delete(i);
      end
      if (bus0.ex_valid_i && bus0.ex_regwr_i && !bus0.flush_i && !st) begin
        l = int'(bus0.ex_lat_i);
        if (l == 0) l = 1;
        if (l > DEPTH) l = DEPTH;
        inflight.push_front('{rd: int'(bus0.ex_rd_i), lat: l, age: 1});
      end
      if (st) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_cnt_sat < CNT_SAT_MAX) m_cnt_sat++;
      end
    end
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    advance();
    rst    = 1'b0;
    chk_en = 1'b1;

    // reset state
    sample();
    chk("rst_sel",   32'(bus0.fwd_sel_o), 0);
    chk("rst_stall", 32'(bus0.stall_o), 0);
    chk("rst_cnt",   32'(bus0.stall_cnt_o), 0);
    advance();

    // ALU back-to-back
    drive(1, 1, 3, LAT_ALU, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 3, 0, 0, 0); sample();
    chk("alu_sel0",  32'(bus0.fwd_sel_o[SW-1:0]), STG_EXMEM);
    chk("alu_stall", 32'(bus0.stall_o), 0);
    advance();

    // load-use
    drive(1, 1, 5, LAT_LOAD, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 0, 5, 0, 0); sample();
    chk("lu_stall",     32'(bus0.stall_o), 1);
    chk("lu_cnt_first", 32'(bus0.stall_cnt_o), 0);
    advance();
    sample();
    chk("lu_sel1",  32'(bus0.fwd_sel_o[2*SW-1:SW]), STG_MEMWB);
    chk("lu_stall_released", 32'(bus0.stall_o), 0);
    chk("lu_cnt",   32'(bus0.stall_cnt_o), 1);
    advance();

    // youngest producer wins
    drive(1, 1, 7, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 1, 7, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 7, 7, 0, 0); sample();
    chk("yw_both_sel", 32'(bus0.fwd_sel_o), 5);
    advance();
    drive(1, 0, 0, 0, 7, 0, 0, 0); sample();
    chk("yw_sel0_stage2", 32'(bus0.fwd_sel_o[SW-1:0]), 2);
    advance();

    // register 0 and flush
    drive(1, 1, 0, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("r0_sel",   32'(bus0.fwd_sel_o), 0);
    chk("r0_stall", 32'(bus0.stall_o), 0);
    advance();
    drive(1, 1, 9, 1, 0, 0, 1, 0); sample(); advance();
    drive(1, 0, 0, 0, 9, 0, 0, 0); sample();
    chk("flush_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 0);
    advance();

    // latency 0 behaves as latency 1
    drive(1, 1, 2, 0, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 2, 0, 0, 0); sample();
    chk("clamp_sel0",  32'(bus0.fwd_sel_o[SW-1:0]), 1);
    chk("clamp_stall", 32'(bus0.stall_o), 0);
    advance();

    // hold and retire
    drive(1, 1, 4, LAT_ALU, 0, 0, 0, 0); sample(); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 4, 0, 0, 1); sample();
      chk("hold_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 1);
      chk("hold_cnt",  32'(bus0.stall_cnt_o), 1);
      advance();
    end
    drive(1, 0, 0, 0, 4, 0, 0, 0); sample();
    chk("release_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 1);
    advance();
    sample(); chk("age2_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 2); advance();
    sample(); chk("age3_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 3); advance();
    sample(); chk("retired_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 0); advance();

    // stall under hold is not counted
    drive(1, 1, 8, LAT_LOAD, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 8, 0, 0, 1); sample();
    chk("hstall_stall", 32'(bus0.stall_o), 1);
    advance();
    sample();
    chk("hstall_cnt", 32'(bus0.stall_cnt_o), 1);
    advance();
    drive(1, 0, 0, 0, 8, 0, 0, 0); sample(); advance();
    sample();
    chk("hstall_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 2);
    chk("hstall_cnt2", 32'(bus0.stall_cnt_o), 2);
    advance();

    // flush during stall, counter saturation on the narrow counter
    drive(1, 1, 10, 3, 0, 0, 0, 0); sample(); advance();
    drive(1, 1, 12, 1, 10, 0, 1, 0); sample();
    chk("fs_stall", 32'(bus0.stall_o), 1);
    advance();
    drive(1, 1, 12, 1, 10, 0, 0, 0); sample();
    chk("fs_stall2",  32'(bus0.stall_o), 1);
    chk("sat_cnt_at_max", 32'(bus1.stall_cnt_o), 3);
    advance();
    sample();
    chk("fs_sel0_age3", 32'(bus0.fwd_sel_o[SW-1:0]), 3);
    chk("fs_cnt",       32'(bus0.stall_cnt_o), 4);
    chk("sat_cnt_held", 32'(bus1.stall_cnt_o), 3);
    advance();
    drive(1, 0, 0, 0, 12, 0, 0, 0); sample();
    chk("fs_rd12_sel0", 32'(bus0.fwd_sel_o[SW-1:0]), 1);
    advance();
    drive(1, 1, 11, 3, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 11, 0, 0, 0); sample(); advance();
    sample(); advance();
    sample();
    chk("sat_cnt_wide",   32'(bus0.stall_cnt_o), 6);
    chk("sat_cnt_narrow", 32'(bus1.stall_cnt_o), 3);
    advance();

    // reset mid-flight
    drive(1, 1, 1, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 1, 2, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 1, 3, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 0, 1, 2, 0, 0); sample();
    chk("mid_sel", 32'(bus0.fwd_sel_o), 11);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    sample();
    chk("mrst_sel",     32'(bus0.fwd_sel_o), 0);
    chk("mrst_stall",   32'(bus0.stall_o), 0);
    chk("mrst_cnt",     32'(bus0.stall_cnt_o), 0);
    chk("mrst_cnt_sat", 32'(bus1.stall_cnt_o), 0);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
